counter_updown_param_async_resetb: RTL
======================================

COUNTER_UPDOWN_PARAM_ASYNC_RESETB -- requirements
Module: counter_updown_param_async_resetb

Interface
REQ-001 Parameter WIDTH, default 128: counter and limit width in bits, range 2..128.
REQ-002 Parameter PW, default 8: prescaler width in bits, range 1..16.
REQ-003 clk  input  1  rising-edge clock; the block's only clock.
REQ-004 resetb  input  1  asynchronous active-low reset.
REQ-005 en  input  1  count enable; prescaler and counter hold when 0.
REQ-006 dir  input  1  step direction: 1 = up, 0 = down.
REQ-007 mode  input  1  boundary behaviour: 0 = wrap, 1 = saturate.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value written on load.
REQ-010 limit  input  WIDTH  upper bound; the count range is 0..limit inclusive.
REQ-011 prescale  input  PW  a step occurs once every prescale+1 enabled cycles.
REQ-012 ovf_clr  input  1  clears the sticky overflow flag.
REQ-013 result  output  WIDTH  current count, registered.
REQ-014 tc  output  1  terminal-count pulse, registered, one cycle wide per boundary event.
REQ-015 ovf  output  1  sticky boundary-event flag, registered.

Function
REQ-016 Internal prescaler register pre_cnt, PW bits.
REQ-017 Priority per rising edge, highest first: load, step, hold.
REQ-018 Load:
- result <= min(load_val, limit).
- pre_cnt <= 0.
- tc <= 0.
- ovf is unchanged except through ovf_clr.
REQ-019 en=0 and load=0: result and pre_cnt hold; tc <= 0.
REQ-020 en=1 and load=0:
- If pre_cnt >= prescale: step cycle, and pre_cnt <= 0.
- Otherwise: pre_cnt <= pre_cnt+1, no step, tc <= 0.
REQ-021 prescale=0: every enabled cycle is a step cycle.
REQ-022 Up step with result < limit: result <= result+1, tc <= 0.
REQ-023 Up step with result >= limit is a boundary event:
- wrap: result <= 0.
- saturate: result <= limit.
REQ-024 Down step with 0 < result <= limit: result <= result-1, tc <= 0.
REQ-025 Down step with result > limit (limit lowered at run time): result <= limit; this is not a boundary event.
REQ-026 Down step with result == 0 is a boundary event:
- wrap: result <= limit.
- saturate: result <= 0.
REQ-027 Every boundary event sets tc <= 1 for exactly that cycle and sets ovf <= 1.
REQ-028 Saturate mode, counter held at a boundary: every further step re-asserts tc for one cycle; tc stays low on non-step cycles.
REQ-029 limit=0: result stays 0 and every step is a boundary event.
REQ-030 ovf_clr=1 clears ovf; if a boundary event occurs in the same cycle, the set wins and ovf = 1.
REQ-031 Arithmetic is modulo 2^WIDTH. No internal carry or borrow is observable beyond tc and ovf.
REQ-032 limit, mode, dir and prescale are sampled every cycle; changes take effect on the next step with no restart.

Reset
REQ-033 resetb=0 asynchronously forces result=0, pre_cnt=0, tc=0 and ovf=0, independent of clk.
REQ-034 While resetb=0, all state holds at its reset value, including while load or en is asserted.
REQ-035 Reset applied mid-count, mid-prescale or during a tc pulse aborts the operation immediately; no partial update survives.
REQ-036 After resetb rises, the first rising clk edge is processed normally under REQ-017 to REQ-032.

Verification (WIDTH=8, PW=4)
REQ-037 Prescaled up count:
- Stimulus: resetb pulse; en=1, dir=1, mode=0, limit=255, prescale=3.
- Response: result increments every 4th cycle: 0,0,0,0,1,1,1,1,2.
REQ-038 Up wrap:
- Stimulus: limit=9, prescale=0, up, wrap, 12 cycles from 0.
- Response: result 0..9 then 0,1; tc high exactly on the cycle result returns to 0; ovf=1 afterwards.
REQ-039 Down saturate:
- Stimulus: load_val=2, load; then down, mode=1, prescale=0, 5 cycles.
- Response: result 2,1,0,0,0; tc high on each of the last two steps; ovf=1.
REQ-040 Load clamp and priority:
- Stimulus: limit=20, load_val=200, load=1 and en=1 together.
- Response: result=20 and pre_cnt=0 next cycle; tc=0.
REQ-041 ovf clear race:
- Stimulus: ovf_clr=1 on the same cycle as a boundary event.
- Response: ovf remains 1.
- Stimulus: ovf_clr=1 on a later cycle with no boundary event.
- Response: ovf=0.
REQ-042 Asynchronous reset:
- Stimulus: assert resetb=0 between clk edges while result=0x37, en=1.
- Response: result=0, tc=0 and ovf=0 immediately, before the next edge; they hold through 3 clk edges while resetb=0.

Source files
------------

// File: rtl/counter_updown_param_async_resetb_if.sv
// rtl/counter_updown_param_async_resetb_if.sv - control and status bundle for the up/down counter
interface counter_updown_param_async_resetb_if #(
    parameter int WIDTH = 128,
    parameter int PW    = 8
);
    logic             en;
    logic             dir;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic [PW-1:0]    prescale;
    logic             ovf_clr;
    logic [WIDTH-1:0] result;
    logic             tc;
    logic             ovf;

    modport master (
        output en, dir, mode, load, load_val, limit, prescale, ovf_clr,
        input  result, tc, ovf
    );

    modport slave (
        input  en, dir, mode, load, load_val, limit, prescale, ovf_clr,
        output result, tc, ovf
    );
endinterface

// File: rtl/counter_updown_param_async_resetb.sv
// rtl/counter_updown_param_async_resetb.sv - prescaled up/down counter with limit, wrap/saturate and sticky overflow
module counter_updown_param_async_resetb #(
    parameter int WIDTH = 128,
    parameter int PW    = 8
) (
    input  logic                                  clk,
    input  logic                                  resetb,
    counter_updown_param_async_resetb_if.slave    bus
);
    logic [WIDTH-1:0] result;
    logic [PW-1:0]    pre_cnt;
    logic             tc;
    logic             ovf;

    logic             step;
    logic             boundary;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_clamped;

    always_comb begin
        step         = 1'b0;
        boundary     = 1'b0;
        step_val     = result;
        load_clamped = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;

        if (!bus.load && bus.en && (pre_cnt >= bus.prescale)) begin
            step = 1'b1;
        end

        if (bus.dir) begin
            if (result >= bus.limit) begin
                boundary = step;
                step_val = bus.mode ? bus.limit : '0;
            end else begin
                step_val = result + 1'b1;
            end
        end else begin
            // A count left above a freshly lowered limit snaps down without flagging.
            if (result == '0) begin
                boundary = step;
                step_val = bus.mode ? '0 : bus.limit;
            end else if (result > bus.limit) begin
                step_val = bus.limit;
            end else begin
                step_val = result - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            result  <= '0;
            pre_cnt <= '0;
            tc      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            tc <= boundary;

            if (bus.load) begin
                result  <= load_clamped;
                pre_cnt <= '0;
            end else if (bus.en) begin
                if (step) begin
                    result  <= step_val;
                    pre_cnt <= '0;
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
            end

            // Set has priority over clear when both land in the same cycle.
            if (boundary) begin
                ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign bus.result = result;
    assign bus.tc     = tc;
    assign bus.ovf    = ovf;
endmodule
